lfsr_checker: RTL

- Downstream consumer of the 16-bit Galois LFSR pattern generator.
- Samples the generator's Q output and locks onto the sequence.
- Once locked, predicts each following value, flags and counts mismatches, and confirms the full 65535-state period on every return to the seed.
- Used as the self-checking receive side of the PRBS path.

---
 rtl/lfsr_checker_if.sv | 24 ++
 rtl/lfsr_checker.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker_if.sv
// rtl/lfsr_checker_if.sv - sample/status bundle between an LFSR source and lfsr_checker
`timescale 1ns/1ps
interface lfsr_checker_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] q_in;
  logic             valid;
  logic             clr_err;
  logic             locked;
  logic             error;
  logic [15:0]      err_count;
  logic             wrap;
  logic             zero_stuck;

  modport master (
    output q_in, valid, clr_err,
    input  locked, error, err_count, wrap, zero_stuck
  );

  modport slave (
    input  q_in, valid, clr_err,
    output locked, error, err_count, wrap, zero_stuck
  );
endinterface

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - 16-bit Galois LFSR sequence checker; LFSR_CHK_ZERO_DETECT_EN adds the zero-lockup flag
`timescale 1ns/1ps
module lfsr_checker #(
  parameter int              WIDTH        = 16,
  parameter logic [15:0]     TAPS         = 16'hB400,
  parameter logic [15:0]     SEED         = 16'hACE1,
  parameter int              LOCK_COUNT   = 4,
  parameter int              UNLOCK_COUNT = 3
) (
  input  logic           clk,
  input  logic           rst,
  lfsr_checker_if.slave  bus
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int UW = $clog2(UNLOCK_COUNT + 1);
  localparam logic [MW-1:0] LOCK_N   = MW'(LOCK_COUNT);
  localparam logic [UW-1:0] UNLOCK_N = UW'(UNLOCK_COUNT);
  localparam logic [16:0]   PERIOD_N = 17'd65535;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] lfsr_nxt(input logic [WIDTH-1:0] x);
    return (x >> 1) ^ (x[0] ? TAPS : '0);
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pred_q, pred_d;
  logic [MW-1:0]    match_cnt_q, match_cnt_d;
  logic [UW-1:0]    miss_cnt_q, miss_cnt_d;
  logic [16:0]      period_cnt_q, period_cnt_d;
  logic             armed_q, armed_d;
  logic             locked_q, locked_d;
  logic             error_q, error_d;
  logic             wrap_q, wrap_d;
  logic [15:0]      err_count_q, err_count_d;

  logic             sample_hit;
  logic             sample_zero;
  logic             sample_seed;
  logic [MW-1:0]    match_inc;
  logic [UW-1:0]    miss_inc;
  logic [16:0]      period_inc;
  logic [15:0]      err_count_inc;

  assign sample_hit    = (bus.q_in == pred_q);
  assign sample_zero   = (bus.q_in == '0);
  assign sample_seed   = (bus.q_in == SEED);
  assign match_inc     = match_cnt_q + MW'(1);
  assign miss_inc      = miss_cnt_q + UW'(1);
  assign period_inc    = period_cnt_q + 17'd1;
  assign err_count_inc = (err_count_q == 16'hFFFF) ? err_count_q : err_count_q + 16'd1;

  // Hunt/sync/lock sequencing, flywheel prediction, error and period accounting.
  always_comb begin
    state_d      = state_q;
    pred_d       = pred_q;
    match_cnt_d  = match_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    period_cnt_d = period_cnt_q;
    armed_d      = armed_q;
    err_count_d  = err_count_q;
    error_d      = 1'b0;
    wrap_d       = 1'b0;
    if (bus.valid) begin
      case (state_q)
        ST_HUNT: begin
          // All-zero is the LFSR lockup value; there is no sequence to follow.
          if (!sample_zero) begin
            pred_d      = lfsr_nxt(bus.q_in);
            match_cnt_d = '0;
            state_d     = ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (sample_hit) begin
            match_cnt_d = match_inc;
            pred_d      = lfsr_nxt(bus.q_in);
            if (match_inc == LOCK_N) begin
              state_d    = ST_LOCKED;
              miss_cnt_d = '0;
              armed_d    = 1'b0;
            end
          end else if (sample_zero) begin
            state_d = ST_HUNT;
          end else begin
            pred_d      = lfsr_nxt(bus.q_in);
            match_cnt_d = '0;
          end
        end
        ST_LOCKED: begin
          // Prediction free-runs so a corrupted sample never pulls us off the sequence.
          pred_d = lfsr_nxt(pred_q);
          if (sample_hit) begin
            miss_cnt_d = '0;
            if (sample_seed) begin
              wrap_d       = armed_q && (period_inc == PERIOD_N);
              period_cnt_d = '0;
              armed_d      = 1'b1;
            end else begin
              period_cnt_d = period_inc;
            end
          end else begin
            error_d      = 1'b1;
            err_count_d  = err_count_inc;
            miss_cnt_d   = miss_inc;
            period_cnt_d = period_inc;
            if (miss_inc == UNLOCK_N) begin
              state_d = ST_HUNT;
              armed_d = 1'b0;
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
    if (bus.clr_err) begin
      err_count_d = '0;
    end
    locked_d = (state_d == ST_LOCKED);
  end

  // State and registered outputs; reset takes effect immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_HUNT;
      pred_q       <= '0;
      match_cnt_q  <= '0;
      miss_cnt_q   <= '0;
      period_cnt_q <= '0;
      armed_q      <= 1'b0;
      locked_q     <= 1'b0;
      error_q      <= 1'b0;
      wrap_q       <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      pred_q       <= pred_d;
      match_cnt_q  <= match_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      period_cnt_q <= period_cnt_d;
      armed_q      <= armed_d;
      locked_q     <= locked_d;
      error_q      <= error_d;
      wrap_q       <= wrap_d;
      err_count_q  <= err_count_d;
    end
  end

  assign bus.locked    = locked_q;
  assign bus.error     = error_q;
  assign bus.wrap      = wrap_q;
  assign bus.err_count = err_count_q;

`ifdef LFSR_CHK_ZERO_DETECT_EN
  logic zero_stuck_q, zero_stuck_d;

  // Sticky lockup flag: a valid all-zero sample sets it, CLR_ERR clears it.
  always_comb begin
    zero_stuck_d = zero_stuck_q;
    if (bus.clr_err) begin
      zero_stuck_d = 1'b0;
    end
    if (bus.valid && sample_zero) begin
      zero_stuck_d = 1'b1;
    end
  end

  // Lockup flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_stuck_q <= 1'b0;
    end else begin
      zero_stuck_q <= zero_stuck_d;
    end
  end

  assign bus.zero_stuck = zero_stuck_q;
`else
  assign bus.zero_stuck = 1'b0;
`endif

endmodule
